// File: rtl/pulse_scheduler_if.sv
// pulse_scheduler_if: request/grant and phase-flag bundle
// between the requesting logic and the pulse scheduler.
interface pulse_scheduler_if #(
   parameter int NREQ = 4,
   parameter int CW   = 8
);
   logic [NREQ-1:0] REQ;
   logic [CW-1:0]   PRE_LEN;
   logic [CW-1:0]   PULSE_LEN;
   logic [CW-1:0]   GAP_LEN;
   logic [NREQ-1:0] GNT;
   logic [NREQ-1:0] OWNER;
   logic            DONE;
   logic            BUSY;
   logic            IDLE;
   logic            PRE_PULSE;
   logic            PULSE;

   modport master (
      output REQ, PRE_LEN, PULSE_LEN, GAP_LEN,
      input  GNT, OWNER, DONE, BUSY,
      input  IDLE, PRE_PULSE, PULSE
   );

   modport slave (
      input  REQ, PRE_LEN, PULSE_LEN, GAP_LEN,
      output GNT, OWNER, DONE, BUSY,
      output IDLE, PRE_PULSE, PULSE
   );
endinterface

// File: rtl/pulse_scheduler.sv
// pulse_scheduler: round-robin owner of one pulse resource,
// sequencing IDLE -> PRE_PULSE -> PULSE -> GAP per grant.
module pulse_scheduler #(
   parameter int NREQ = 4,
   parameter int CW   = 8
) (
   input logic             CLK,
   input logic             RSTN,
   pulse_scheduler_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_PRE   = 4'b0010,
      S_PULSE = 4'b0100,
      S_GAP   = 4'b1000
   } state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   pul_s;
   logic [CW-1:0]   gap_s;
   logic [CW-1:0]   pre_s;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] owner;
   logic            done;

   logic [NREQ-1:0] win;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   nxt_ptr;
   logic            found;

   // Zero-length phases still occupy one cycle.
   function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] l);
      return (l == '0) ? '0 : l - 1'b1;
   endfunction

   // Phase flags come straight from the one-hot state register.
   assign bus.IDLE      = state[0];
   assign bus.PRE_PULSE = state[1];
   assign bus.PULSE     = state[2];
   assign bus.BUSY      = ~state[0];
   assign bus.GNT       = gnt;
   assign bus.OWNER     = owner;
   assign bus.DONE      = done;

   // First set request at or after the pointer, wrapping.
   always_comb begin
      win     = '0;
      win_idx = '0;
      idx     = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && bus.REQ[idx]) begin
            found   = 1'b1;
            win     = '0;
            win[idx] = 1'b1;
            win_idx = idx;
         end
      end
      nxt_ptr = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
   end

   // Phase sequencer with latched lengths and registered outputs.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= S_IDLE;
         ptr   <= '0;
         cnt   <= '0;
         pre_s <= '0;
         pul_s <= '0;
         gap_s <= '0;
         gnt   <= '0;
         owner <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  state <= S_PRE;
                  gnt   <= win;
                  owner <= win;
                  ptr   <= nxt_ptr;
                  pre_s <= bus.PRE_LEN;
                  pul_s <= bus.PULSE_LEN;
                  gap_s <= bus.GAP_LEN;
                  cnt   <= len_m1(bus.PRE_LEN);
               end
            end
            S_PRE: begin
               gnt <= '0;
               if (cnt == '0) begin
                  state <= S_PULSE;
                  cnt   <= len_m1(pul_s);
                  done  <= (pul_s <= CW'(1));
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_PULSE: begin
               if (cnt == '0) begin
                  done  <= 1'b0;
                  owner <= '0;
                  if (gap_s != '0) begin
                     state <= S_GAP;
                     cnt   <= gap_s - 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt  <= cnt - 1'b1;
                  done <= (cnt == CW'(1));
               end
            end
            S_GAP: begin
               if (cnt == '0) state <= S_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: begin
               state <= S_IDLE;
               gnt   <= '0;
               owner <= '0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pulse_scheduler.sv
// tb_pulse_scheduler: directed checks of arbitration,
// phase timing, length shadowing and asynchronous reset.
module tb_pulse_scheduler;
   localparam int PI = 0;
   localparam int PP = 1;
   localparam int PU = 2;
   localparam int PG = 3;

   logic CLK;
   logic RSTN;
   int   checks;
   int   failures;

   pulse_scheduler_if #(.NREQ(4), .CW(8)) bus ();

   pulse_scheduler #(.NREQ(4), .CW(8)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_st(input string tag,
                            input logic [3:0] g,
                            input logic [3:0] o,
                            input logic d,
                            input int ph);
      chk({tag, "/gnt"},   32'(bus.GNT),       32'(g));
      chk({tag, "/owner"}, 32'(bus.OWNER),     32'(o));
      chk({tag, "/done"},  32'(bus.DONE),      32'(d));
      chk({tag, "/idle"},  32'(bus.IDLE),      32'(ph == PI));
      chk({tag, "/pre"},   32'(bus.PRE_PULSE), 32'(ph == PP));
      chk({tag, "/pulse"}, 32'(bus.PULSE),     32'(ph == PU));
      chk({tag, "/busy"},  32'(bus.BUSY),      32'(ph != PI));
   endtask

   initial begin
      logic [3:0] g;
      checks    = 0;
      failures  = 0;
      RSTN      = 1'b0;
      bus.REQ       = '0;
      bus.PRE_LEN   = '0;
      bus.PULSE_LEN = '0;
      bus.GAP_LEN   = '0;

      repeat (5) @(posedge CLK);
      #1;
      expect_st("rst", 4'h0, 4'h0, 1'b0, PI);
      RSTN = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         expect_st($sformatf("idle%0d", c), 4'h0, 4'h0, 1'b0, PI);
      end

      // round-robin, all lengths zero, period 3
      bus.REQ = 4'b1111;
      for (int c = 1; c <= 15; c++) begin
         int r;
         r = (c - 1) % 3;
         g = 4'b0001 << (((c - 1) / 3) % 4);
         tick();
         if (r == 0)
            expect_st($sformatf("rr%0d", c), g, g, 1'b0, PP);
         else if (r == 1)
            expect_st($sformatf("rr%0d", c), 4'h0, g, 1'b1, PU);
         else
            expect_st($sformatf("rr%0d", c), 4'h0, 4'h0, 1'b0, PI);
         if (c == 13) bus.REQ = 4'b1001;
      end
      tick();
      expect_st("rr16", 4'b1000, 4'b1000, 1'b0, PP);
      bus.REQ = '0;
      tick();
      expect_st("rr17", 4'h0, 4'b1000, 1'b1, PU);
      tick();
      expect_st("rr18", 4'h0, 4'h0, 1'b0, PI);

      // single request: pre 3, pulse 2, gap 4
      bus.REQ       = 4'b0010;
      bus.PRE_LEN   = 8'd3;
      bus.PULSE_LEN = 8'd2;
      bus.GAP_LEN   = 8'd4;
      tick(); expect_st("s1", 4'b0010, 4'b0010, 1'b0, PP);
      bus.REQ = '0;
      tick(); expect_st("s2", 4'h0, 4'b0010, 1'b0, PP);
      tick(); expect_st("s3", 4'h0, 4'b0010, 1'b0, PP);
      tick(); expect_st("s4", 4'h0, 4'b0010, 1'b0, PU);
      tick(); expect_st("s5", 4'h0, 4'b0010, 1'b1, PU);
      for (int c = 6; c <= 9; c++) begin
         tick();
         expect_st($sformatf("s%0d", c), 4'h0, 4'h0, 1'b0, PG);
      end
      tick(); expect_st("s10", 4'h0, 4'h0, 1'b0, PI);

      // zero lengths with REQ held: PRE, PULSE+DONE, IDLE
      bus.PRE_LEN   = '0;
      bus.PULSE_LEN = '0;
      bus.GAP_LEN   = '0;
      bus.REQ       = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         tick();
         expect_st($sformatf("z%0da", c), 4'b0001, 4'b0001, 1'b0, PP);
         tick();
         expect_st($sformatf("z%0db", c), 4'h0, 4'b0001, 1'b1, PU);
         tick();
         expect_st($sformatf("z%0dc", c), 4'h0, 4'h0, 1'b0, PI);
      end
      bus.REQ = '0;
      tick(); expect_st("z_end", 4'h0, 4'h0, 1'b0, PI);

      // shadowing: PULSE_LEN changed during PRE_PULSE
      bus.REQ       = 4'b0100;
      bus.PRE_LEN   = 8'd2;
      bus.PULSE_LEN = 8'd2;
      tick(); expect_st("sh1", 4'b0100, 4'b0100, 1'b0, PP);
      bus.REQ       = '0;
      bus.PULSE_LEN = 8'd7;
      tick(); expect_st("sh2", 4'h0, 4'b0100, 1'b0, PP);
      tick(); expect_st("sh3", 4'h0, 4'b0100, 1'b0, PU);
      tick(); expect_st("sh4", 4'h0, 4'b0100, 1'b1, PU);
      tick(); expect_st("sh5", 4'h0, 4'h0, 1'b0, PI);
      bus.REQ = 4'b0100;
      tick(); expect_st("sh6", 4'b0100, 4'b0100, 1'b0, PP);
      bus.REQ = '0;
      tick(); expect_st("sh7", 4'h0, 4'b0100, 1'b0, PP);
      for (int c = 0; c < 6; c++) begin
         tick();
         expect_st($sformatf("sh_p%0d", c), 4'h0, 4'b0100, 1'b0, PU);
      end
      tick(); expect_st("sh_last", 4'h0, 4'b0100, 1'b1, PU);
      tick(); expect_st("sh_idle", 4'h0, 4'h0, 1'b0, PI);

      // reset during 2nd PULSE cycle of a 5-cycle pulse
      bus.REQ       = 4'b0011;
      bus.PRE_LEN   = 8'd1;
      bus.PULSE_LEN = 8'd5;
      tick(); expect_st("mr1", 4'b0001, 4'b0001, 1'b0, PP);
      tick(); expect_st("mr2", 4'h0, 4'b0001, 1'b0, PU);
      tick(); expect_st("mr3", 4'h0, 4'b0001, 1'b0, PU);
      #4;
      RSTN = 1'b0;
      #1;
      expect_st("midrst", 4'h0, 4'h0, 1'b0, PI);
      tick(); expect_st("inrst1", 4'h0, 4'h0, 1'b0, PI);
      tick(); expect_st("inrst2", 4'h0, 4'h0, 1'b0, PI);
      #4;
      RSTN = 1'b1;
      tick(); expect_st("regrant", 4'b0001, 4'b0001, 1'b0, PP);
      bus.REQ = '0;
      for (int c = 0; c < 4; c++) begin
         tick();
         expect_st($sformatf("rg_p%0d", c), 4'h0, 4'b0001, 1'b0, PU);
      end
      tick(); expect_st("rg_last", 4'h0, 4'b0001, 1'b1, PU);
      tick(); expect_st("rg_idle", 4'h0, 4'h0, 1'b0, PI);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
